wb_result_buffer: RTL and testbench
===================================

# wb_result_buffer

Result-side endpoint of a WriteBackIO port: a small in-order queue placed between a functional unit (fdiv, fmisc, div, mult) and the writeback arbiter. The unit pushes completed results; the buffer presents the oldest pending result as a WBData record and holds it until the arbiter grants the port through `valid`. Results younger than a pipeline redirect are squashed in place. The buffer lets a unit sharing a writeback lane with a higher-priority source keep completing without stalling.

## Interface
Parameters:
- DEPTH, 4: entries; power of two, ≥2
- XLEN, 32: result width
- ROB_WIDTH, 6: robIdx width; MSB is the wrap (direction) bit, remaining bits are the index
- RD_WIDTH, 7: physical register index width
- EXC_WIDTH, 5: exccode width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_en  in  1  push a result this cycle
- in_we, in_rd, in_res, in_exccode, in_irq_enable, in_robIdx  in  1/RD_WIDTH/XLEN/EXC_WIDTH/1/ROB_WIDTH  WBData payload of the push
- in_ready  out  1  buffer can accept a push this cycle
- out_en  out  1  head entry is live and is offered on the writeback lane
- out_we, out_rd, out_res, out_exccode, out_irq_enable, out_robIdx  out  matching widths  head payload
- wb_valid  in  1  arbiter grant for this lane (WriteBackIO `valid`)
- flush_en  in  1  redirect this cycle
- flush_robIdx  in  ROB_WIDTH  redirecting instruction; strictly younger entries are squashed
- count  out  $clog2(DEPTH)+1  occupied slots, including squashed slots not yet drained

## Operation
- Circular storage with head/tail pointers of $clog2(DEPTH) bits (wrap naturally), a per-slot live bit, and a count register.
- Push: `in_en & in_ready` writes the payload at the tail, sets live = ~(flush_en & younger(in_robIdx, flush_robIdx)), tail+1, count+1. A push while `in_ready`=0 is a protocol violation: it is dropped and a simulation assertion fires.
- in_ready = (count != DEPTH). It is registered-state only; there is no combinational path from wb_valid or flush_en.
- Offer: out_en = (count != 0) & live[head]. The payload is always the head slot's contents.
- Pop: the head leaves (head+1, count−1) when either (a) out_en & wb_valid (written back), or (b) count != 0 & ~live[head] (squashed slot drained; no grant needed). At most one pop per cycle.
- Push and pop in the same cycle: count is unchanged. This is legal when full only for the pop; in_ready is still low that cycle.
- Age compare younger(a,f): if the wrap bits are equal, a.idx > f.idx; otherwise a.idx < f.idx. Equal robIdx is not younger.
- Flush: at the clock edge, every occupied slot whose robIdx is younger than flush_robIdx gets live cleared. Slots are not compacted; they drain through rule (b).
- Flush and grant in the same cycle: the head offered this cycle is written back even if it is younger, because it is already on the bus. The flush applies only to slots remaining after the edge.
- The unit must not push results older than those already queued. Order is FIFO by push.

## Timing
- Reset (asynchronous, immediate): head=tail=0, count=0, all live=0. Outputs: out_en=0, in_ready=1, count=0, payload outputs 0.
- Latency: push at edge t → out_en high from cycle t+1. With continuous grant, it is written back during cycle t+1.
- Throughput: 1 push and 1 pop per cycle.
- A squashed head costs one bubble cycle per slot (out_en=0 while it drains).
- Assertion of rst mid-operation discards all entries. There is no partial state after release.

## Test plan
- Single result: push robIdx=5, res=0xDEADBEEF with wb_valid=1 → out_en=1 on the next cycle with out_res=0xDEADBEEF; the cycle after, count=0 and out_en=0.
- Grant withheld: push 4 results (robIdx 1..4) with wb_valid=0 → count=4, in_ready=0, and the 5th push is dropped with an assertion. Then raise wb_valid → results leave in order 1,2,3,4 on consecutive cycles; in_ready returns to 1 after the first pop.
- Flush: queue robIdx 2,7,3,9 with wb_valid=0, then flush_robIdx=3 → 7 and 9 are squashed. With grant, output shows 2, then 3, and count reaches 0 after two bubble cycles.
- Wrap-aware flush: queue robIdx {1,30},{0,2} with ROB_WIDTH=6, then flush_robIdx={1,31} → {0,2} is squashed and {1,30} survives. Flush together with a younger push → the push enters dead.
- Simultaneous push, pop, and flush at count=DEPTH−1 with a young head granted → the head is written back, count stays DEPTH−1, and the pointers wrap correctly across 3×DEPTH iterations.
- Reset mid-queue with count=3 → outputs return to reset values asynchronously, and a push after release appears one cycle later.

Source files
------------

// File: rtl/wb_result_buffer.sv
// wb_result_buffer: in-order result queue between a functional unit and the writeback arbiter.
// Squashed entries stay in place and drain one per cycle without needing a grant.
module wb_result_buffer #(
  parameter int DEPTH     = 4,
  parameter int XLEN      = 32,
  parameter int ROB_WIDTH = 6,
  parameter int RD_WIDTH  = 7,
  parameter int EXC_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_en,
  input  logic                         in_we,
  input  logic [RD_WIDTH-1:0]          in_rd,
  input  logic [XLEN-1:0]              in_res,
  input  logic [EXC_WIDTH-1:0]         in_exccode,
  input  logic                         in_irq_enable,
  input  logic [ROB_WIDTH-1:0]         in_robIdx,
  output logic                         in_ready,
  output logic                         out_en,
  output logic                         out_we,
  output logic [RD_WIDTH-1:0]          out_rd,
  output logic [XLEN-1:0]              out_res,
  output logic [EXC_WIDTH-1:0]         out_exccode,
  output logic                         out_irq_enable,
  output logic [ROB_WIDTH-1:0]         out_robIdx,
  input  logic                         wb_valid,
  input  logic                         flush_en,
  input  logic [ROB_WIDTH-1:0]         flush_robIdx,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int AW = $clog2(DEPTH);
  logic                 we_q   [DEPTH];
  logic [RD_WIDTH-1:0]  rd_q   [DEPTH];
  logic [XLEN-1:0]      res_q  [DEPTH];
  logic [EXC_WIDTH-1:0] exc_q  [DEPTH];
  logic                 irq_q  [DEPTH];
  logic [ROB_WIDTH-1:0] rob_q  [DEPTH];
  logic                 live_q [DEPTH];
  logic [AW-1:0]        head, tail;
  logic [AW:0]          cnt;
  logic                 push, pop;
  function automatic logic younger(input logic [ROB_WIDTH-1:0] a, input logic [ROB_WIDTH-1:0] f);
    return (a[ROB_WIDTH-1] == f[ROB_WIDTH-1]) ? (a[ROB_WIDTH-2:0] > f[ROB_WIDTH-2:0])
                                              : (a[ROB_WIDTH-2:0] < f[ROB_WIDTH-2:0]);
  endfunction
  assign in_ready       = cnt != (AW+1)'(DEPTH);
  assign out_en         = (cnt != '0) & live_q[head];
  assign push           = in_en & in_ready;
  // a dead head leaves without a grant; a live head leaves only when granted
  assign pop            = (cnt != '0) & (~live_q[head] | wb_valid);
  assign count          = cnt;
  assign out_we         = we_q[head];
  assign out_rd         = rd_q[head];
  assign out_res        = res_q[head];
  assign out_exccode    = exc_q[head];
  assign out_irq_enable = irq_q[head];
  assign out_robIdx     = rob_q[head];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        we_q[i]   <= 1'b0;
        rd_q[i]   <= '0;
        res_q[i]  <= '0;
        exc_q[i]  <= '0;
        irq_q[i]  <= 1'b0;
        rob_q[i]  <= '0;
        live_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        tail        <= tail + 1'b1;
        we_q[tail]  <= in_we;
        rd_q[tail]  <= in_rd;
        res_q[tail] <= in_res;
        exc_q[tail] <= in_exccode;
        irq_q[tail] <= in_irq_enable;
        rob_q[tail] <= in_robIdx;
      end
      if (pop) head <= head + 1'b1;
      if (push != pop) cnt <= push ? cnt + 1'b1 : cnt - 1'b1;
      // the granted head has already left; clearing a freed slot's live bit is harmless
      for (int i = 0; i < DEPTH; i++)
        if (push && AW'(i) == tail) live_q[i] <= ~(flush_en & younger(in_robIdx, flush_robIdx));
        else if (flush_en && younger(rob_q[i], flush_robIdx)) live_q[i] <= 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (!rst && in_en) assert (in_ready) else $error("wb_result_buffer: push while full dropped");
endmodule

// File: tb/tb_wb_result_buffer.sv
// tb_wb_result_buffer: queue-model scoreboard plus directed literal checks for wb_result_buffer.
module tb_wb_result_buffer;
  localparam int DEPTH = 4;
  localparam int RW    = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_en = 1'b0, in_we = 1'b0, in_irq_enable = 1'b0;
  logic [6:0] in_rd = '0;
  logic [31:0] in_res = '0;
  logic [4:0] in_exccode = '0;
  logic [RW-1:0] in_robIdx = '0, flush_robIdx = '0;
  logic wb_valid = 1'b0, flush_en = 1'b0;
  logic in_ready, out_en, out_we, out_irq_enable;
  logic [6:0] out_rd;
  logic [31:0] out_res;
  logic [4:0] out_exccode;
  logic [RW-1:0] out_robIdx;
  logic [2:0] count;
  int n_chk = 0, n_fail = 0;

  wb_result_buffer #(.DEPTH(DEPTH), .XLEN(32), .ROB_WIDTH(RW), .RD_WIDTH(7), .EXC_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_we(in_we), .in_rd(in_rd), .in_res(in_res),
    .in_exccode(in_exccode), .in_irq_enable(in_irq_enable), .in_robIdx(in_robIdx),
    .in_ready(in_ready), .out_en(out_en), .out_we(out_we), .out_rd(out_rd), .out_res(out_res),
    .out_exccode(out_exccode), .out_irq_enable(out_irq_enable), .out_robIdx(out_robIdx),
    .wb_valid(wb_valid), .flush_en(flush_en), .flush_robIdx(flush_robIdx), .count(count));

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [6:0] rd; logic [31:0] res; logic [4:0] exc; logic irq; logic [RW-1:0] rob; logic live;
  } ent_t;
  ent_t q[$];
  ent_t m_e;
  bit m_push, m_pop;

  // younger means the forward distance from f to a is in the first half of the robIdx ring
  function automatic bit yng(input logic [RW-1:0] a, input logic [RW-1:0] f);
    logic [RW-1:0] d;
    d = a - f;
    return d != 0 && int'(d) < (1 << (RW - 1));
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) q.delete();
    else begin
      m_push = in_en && q.size() != DEPTH;
      m_pop  = q.size() != 0 && (!q[0].live || wb_valid);
      if (m_pop) void'(q.pop_front());
      if (flush_en) foreach (q[i]) if (yng(q[i].rob, flush_robIdx)) q[i].live = 1'b0;
      if (m_push) begin
        m_e = '{in_we, in_rd, in_res, in_exccode, in_irq_enable, in_robIdx, 1'b1};
        m_e.live = !(flush_en && yng(in_robIdx, flush_robIdx));
        q.push_back(m_e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_count", 64'(count), 64'(q.size()));
      chk("m_in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
      if (q.size() == 0) chk("m_out_en_empty", 64'(out_en), 64'(0));
      else begin
        chk("m_out_en", 64'(out_en), 64'(q[0].live));
        if (q[0].live) begin
          chk("m_we", 64'(out_we), 64'(q[0].we));
          chk("m_rd", 64'(out_rd), 64'(q[0].rd));
          chk("m_res", 64'(out_res), 64'(q[0].res));
          chk("m_exc", 64'(out_exccode), 64'(q[0].exc));
          chk("m_irq", 64'(out_irq_enable), 64'(q[0].irq));
          chk("m_rob", 64'(out_robIdx), 64'(q[0].rob));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [RW-1:0] r, input logic [31:0] v);
    in_en = 1'b1; in_robIdx = r; in_res = v; in_rd = 7'(r) + 7'd1;
    in_exccode = r[4:0]; in_we = r[0]; in_irq_enable = r[1];
    tick();
    in_en = 1'b0;
  endtask

  logic [RW-1:0] t3 [4] = '{6'd2, 6'd7, 6'd3, 6'd9};

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("reset_out_en", 64'(out_en), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_count", 64'(count), 64'(0));
    chk("reset_res", 64'(out_res), 64'(0));
    // single result with continuous grant
    wb_valid = 1'b1;
    push(6'd5, 32'hDEADBEEF);
    chk("t1_out_en", 64'(out_en), 64'(1));
    chk("t1_res", 64'(out_res), 64'hDEADBEEF);
    chk("t1_rob", 64'(out_robIdx), 64'(5));
    tick();
    chk("t1_count", 64'(count), 64'(0));
    chk("t1_out_en_after", 64'(out_en), 64'(0));
    // grant withheld until full
    wb_valid = 1'b0;
    for (int r = 1; r <= 4; r++) push(6'(r), 32'h100 + r);
    chk("t2_count_full", 64'(count), 64'(4));
    chk("t2_in_ready_full", 64'(in_ready), 64'(0));
    chk("t2_head1", 64'(out_robIdx), 64'(1));
    wb_valid = 1'b1;
    tick();
    chk("t2_in_ready_back", 64'(in_ready), 64'(1));
    chk("t2_head2", 64'(out_robIdx), 64'(2));
    chk("t2_count3", 64'(count), 64'(3));
    tick(); tick(); tick();
    chk("t2_empty", 64'(count), 64'(0));
    // flush squashes 7 and 9
    wb_valid = 1'b0;
    for (int i = 0; i < 4; i++) push(t3[i], 32'h200 + 32'(t3[i]));
    flush_en = 1'b1; flush_robIdx = 6'd3;
    tick();
    flush_en = 1'b0;
    chk("t3_count", 64'(count), 64'(4));
    chk("t3_head2", 64'(out_robIdx), 64'(2));
    wb_valid = 1'b1;
    tick();
    chk("t3_bubble1", 64'(out_en), 64'(0));
    tick();
    chk("t3_head3_en", 64'(out_en), 64'(1));
    chk("t3_head3", 64'(out_robIdx), 64'(3));
    tick();
    chk("t3_bubble2", 64'(out_en), 64'(0));
    tick();
    chk("t3_empty", 64'(count), 64'(0));
    // wrap-aware flush {1,31} with a younger push entering dead
    wb_valid = 1'b0;
    push(6'd62, 32'h300);
    push(6'd2, 32'h301);
    flush_en = 1'b1; flush_robIdx = 6'd63;
    push(6'd5, 32'h302);
    flush_en = 1'b0;
    chk("t4_count", 64'(count), 64'(3));
    chk("t4_head_live", 64'(out_en), 64'(1));
    chk("t4_head_rob", 64'(out_robIdx), 64'(62));
    wb_valid = 1'b1;
    tick();
    chk("t4_dead_head", 64'(out_en), 64'(0));
    chk("t4_count2", 64'(count), 64'(2));
    tick(); tick();
    chk("t4_empty", 64'(count), 64'(0));
    // push + pop + flush at DEPTH-1 across pointer and robIdx wrap
    wb_valid = 1'b0;
    for (int r = 58; r <= 60; r++) push(6'(r), 32'h400 + r);
    wb_valid = 1'b1;
    for (int k = 61; k < 61 + 3 * DEPTH; k++) begin
      flush_en = (k % 3 == 0);
      flush_robIdx = 6'(k - 4);
      push(6'(k), 32'h500 + k);
      chk("t5_count_steady", 64'(count), 64'(DEPTH - 1));
    end
    flush_en = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t5_drained", 64'(count), 64'(0));
    // asynchronous reset mid-queue
    wb_valid = 1'b0;
    for (int r = 20; r <= 22; r++) push(6'(r), 32'h600 + r);
    chk("t6_count3", 64'(count), 64'(3));
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_out_en", 64'(out_en), 64'(0));
    chk("t6_rst_in_ready", 64'(in_ready), 64'(1));
    chk("t6_rst_count", 64'(count), 64'(0));
    chk("t6_rst_res", 64'(out_res), 64'(0));
    chk("t6_rst_rob", 64'(out_robIdx), 64'(0));
    tick(); tick();
    rst = 1'b0;
    push(6'd33, 32'hCAFE0001);
    chk("t6_post_en", 64'(out_en), 64'(1));
    chk("t6_post_rob", 64'(out_robIdx), 64'(33));
    chk("t6_post_count", 64'(count), 64'(1));
    wb_valid = 1'b1;
    tick();
    chk("t6_final_empty", 64'(count), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
